// File: rtl/aes_io_sequencer.sv
// Valid/ready sequencer for a two-share masked AES core: holds the active block stable,
// queues one look-ahead block, captures the ciphertext shares and watches for a hung core.
module aes_io_sequencer #(
    parameter int W             = 128,
    parameter int CAPTURE_DELAY = 0,
    parameter int TIMEOUT       = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pt0,
    input  logic [W-1:0] in_pt1,
    input  logic [W-1:0] in_key0,
    input  logic [W-1:0] in_key1,
    output logic         core_rst,
    output logic [W-1:0] core_pt0,
    output logic [W-1:0] core_pt1,
    output logic [W-1:0] core_key0,
    output logic [W-1:0] core_key1,
    input  logic         core_done,
    input  logic [W-1:0] core_ct0,
    input  logic [W-1:0] core_ct1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ct0,
    output logic [W-1:0] out_ct1,
    output logic         busy,
    output logic         err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int DW = (CAPTURE_DELAY > 0) ? $clog2(CAPTURE_DELAY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAP,
        S_OUT,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_act [4];
    logic [W-1:0]  r_nxt [4];
    logic [W-1:0]  w_in_blk [4];
    logic          r_nxt_full;
    logic [W-1:0]  r_ct0;
    logic [W-1:0]  r_ct1;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_plus;
    logic [DW-1:0] r_dly;

    logic w_in_ready;
    logic w_core_rst;
    logic w_busy;
    logic w_out_valid;
    logic w_err;
    logic w_ld_act;
    logic w_promote;
    logic w_clr_act;
    logic w_ld_nxt;
    logic w_capture;
    logic w_clr_out;
    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_dly_load;
    logic w_dly_dec;

    // Block word order: pt0, pt1, key0, key1.
    assign w_in_blk[0] = in_pt0;
    assign w_in_blk[1] = in_pt1;
    assign w_in_blk[2] = in_key0;
    assign w_in_blk[3] = in_key1;
    assign w_cnt_plus  = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_core_rst   = 1'b1;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        w_err        = 1'b0;
        w_ld_act     = 1'b0;
        w_promote    = 1'b0;
        w_clr_act    = 1'b0;
        w_ld_nxt     = 1'b0;
        w_capture    = 1'b0;
        w_clr_out    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_dly_load   = 1'b0;
        w_dly_dec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_ld_act     = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = ~r_nxt_full;
                w_core_rst = 1'b0;
                w_busy     = 1'b1;
                w_ld_nxt   = in_valid & ~r_nxt_full;
                w_cnt_inc  = 1'b1;
                // core_done wins over a timeout landing on the same cycle.
                if (core_done) begin
                    if (CAPTURE_DELAY == 0) begin
                        w_capture    = 1'b1;
                        w_clr_act    = 1'b1;
                        w_state_next = S_OUT;
                    end else begin
                        w_dly_load   = 1'b1;
                        w_state_next = S_CAP;
                    end
                end else if (w_cnt_plus == CW'(TIMEOUT)) begin
                    w_state_next = S_ERR;
                end
            end
            S_CAP: begin
                w_in_ready = ~r_nxt_full;
                w_core_rst = 1'b0;
                w_busy     = 1'b1;
                w_ld_nxt   = in_valid & ~r_nxt_full;
                if (r_dly == DW'(1)) begin
                    w_capture    = 1'b1;
                    w_clr_act    = 1'b1;
                    w_state_next = S_OUT;
                end else begin
                    w_dly_dec = 1'b1;
                end
            end
            S_OUT: begin
                w_in_ready  = ~r_nxt_full;
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_clr_out = 1'b1;
                    if (r_nxt_full) begin
                        w_promote    = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_RUN;
                    end else if (in_valid) begin
                        // A block arriving with the result handshake skips the queue.
                        w_ld_act     = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_ld_nxt = in_valid & ~r_nxt_full;
                end
            end
            S_ERR: begin
                w_err = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_act[i] <= '0;
                r_nxt[i] <= '0;
            end
            r_nxt_full <= 1'b0;
            r_ct0      <= '0;
            r_ct1      <= '0;
            r_cnt      <= '0;
            r_dly      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_ld_act) begin
                    r_act[i] <= w_in_blk[i];
                end else if (w_promote) begin
                    r_act[i] <= r_nxt[i];
                end else if (w_clr_act) begin
                    r_act[i] <= '0;
                end
                if (w_ld_nxt) begin
                    r_nxt[i] <= w_in_blk[i];
                end else if (w_promote) begin
                    r_nxt[i] <= '0;
                end
            end
            if (w_ld_nxt) begin
                r_nxt_full <= 1'b1;
            end else if (w_promote) begin
                r_nxt_full <= 1'b0;
            end
            if (w_capture) begin
                r_ct0 <= core_ct0;
                r_ct1 <= core_ct1;
            end else if (w_clr_out) begin
                r_ct0 <= '0;
                r_ct1 <= '0;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= w_cnt_plus;
            end
            if (w_dly_load) begin
                r_dly <= DW'(CAPTURE_DELAY);
            end else if (w_dly_dec) begin
                r_dly <= r_dly - DW'(1);
            end
        end
    end

    assign in_ready  = w_in_ready & rst;
    assign core_rst  = w_core_rst;
    assign busy      = w_busy;
    assign out_valid = w_out_valid;
    assign err       = w_err;
    assign core_pt0  = r_act[0];
    assign core_pt1  = r_act[1];
    assign core_key0 = r_act[2];
    assign core_key1 = r_act[3];
    assign out_ct0   = r_ct0;
    assign out_ct1   = r_ct1;

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Directed bench for aes_io_sequencer: instance a uses CAPTURE_DELAY=0, instance b uses 6,
// both with TIMEOUT=100 and driven from the same stimulus.
module tb_aes_io_sequencer;
    localparam int W = 128;
    localparam logic [W-1:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [W-1:0] MASK = 128'h0123456789abcdeffedcba9876543210;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_pt0 = '0, in_pt1 = '0, in_key0 = '0, in_key1 = '0;
    logic         core_done = 1'b0;
    logic [W-1:0] core_ct0 = '0, core_ct1 = '0;
    logic         out_ready = 1'b0;

    logic         a_in_ready, a_core_rst, a_out_valid, a_busy, a_err;
    logic [W-1:0] a_core_pt0, a_core_pt1, a_core_key0, a_core_key1, a_out_ct0, a_out_ct1;
    logic         b_in_ready, b_core_rst, b_out_valid, b_busy, b_err;
    logic [W-1:0] b_core_pt0, b_core_pt1, b_core_key0, b_core_key1, b_out_ct0, b_out_ct1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_io_sequencer #(.W(W), .CAPTURE_DELAY(0), .TIMEOUT(100)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pt0(in_pt0), .in_pt1(in_pt1), .in_key0(in_key0), .in_key1(in_key1),
        .core_rst(a_core_rst), .core_pt0(a_core_pt0), .core_pt1(a_core_pt1),
        .core_key0(a_core_key0), .core_key1(a_core_key1), .core_done(core_done),
        .core_ct0(core_ct0), .core_ct1(core_ct1), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_ct0(a_out_ct0), .out_ct1(a_out_ct1),
        .busy(a_busy), .err(a_err)
    );

    aes_io_sequencer #(.W(W), .CAPTURE_DELAY(6), .TIMEOUT(100)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pt0(in_pt0), .in_pt1(in_pt1), .in_key0(in_key0), .in_key1(in_key1),
        .core_rst(b_core_rst), .core_pt0(b_core_pt0), .core_pt1(b_core_pt1),
        .core_key0(b_core_key0), .core_key1(b_core_key1), .core_done(core_done),
        .core_ct0(core_ct0), .core_ct1(core_ct1), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_ct0(b_out_ct0), .out_ct1(b_out_ct1),
        .busy(b_busy), .err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
        core_ct0 = '0; core_ct1 = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic offer(input logic [W-1:0] p0, input logic [W-1:0] p1,
                         input logic [W-1:0] k0, input logic [W-1:0] k1);
        in_valid = 1'b1; in_pt0 = p0; in_pt1 = p1; in_key0 = k0; in_key1 = k1;
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
        checks++; if (a_core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", a_core_rst); end
        checks++; if ({a_out_valid, a_busy, a_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {a_out_valid, a_busy, a_err}); end
        checks++; if ((a_core_pt0 | a_out_ct0) !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", a_core_pt0 | a_out_ct0); end
        rst = 1'b1; tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", a_in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        offer(PT0, '0, KEY0, '0);
        tick();
        in_valid = 1'b0;
        checks++; if (a_core_rst !== 1'b0) begin errors++; $display("FAIL single_core_rst_run: got %b expected 0", a_core_rst); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", a_busy); end
        repeat (69) tick();
        checks++; if (a_core_pt0 !== PT0 || a_core_key0 !== KEY0) begin errors++; $display("FAIL single_core_block: got %h/%h expected %h/%h", a_core_pt0, a_core_key0, PT0, KEY0); end
        core_done = 1'b1; core_ct0 = CT ^ MASK; core_ct1 = MASK;
        tick();
        core_done = 1'b0; core_ct0 = '1; core_ct1 = '0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", a_out_valid); end
        checks++; if ((a_out_ct0 ^ a_out_ct1) !== CT) begin errors++; $display("FAIL single_ct: got %h expected %h", a_out_ct0 ^ a_out_ct1, CT); end
        checks++; if (a_core_pt0 !== '0 || a_core_rst !== 1'b1) begin errors++; $display("FAIL single_active_zero: got pt0=%h rst=%b expected 0/1", a_core_pt0, a_core_rst); end
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_ct0 !== (CT ^ MASK)) begin errors++; $display("FAIL single_hold: got v=%b ct0=%h expected 1/%h", a_out_valid, a_out_ct0, CT ^ MASK); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || (a_out_ct0 | a_out_ct1) !== '0) begin errors++; $display("FAIL single_out_clear: got v=%b ct=%h expected 0/0", a_out_valid, a_out_ct0 | a_out_ct1); end
        checks++; if (a_in_ready !== 1'b1 || a_core_rst !== 1'b1) begin errors++; $display("FAIL single_back_idle: got rdy=%b rst=%b expected 1/1", a_in_ready, a_core_rst); end
        $display("test_single done");
    endtask

    task automatic test_queued();
        do_reset();
        offer(128'hA0, 128'hA1, 128'hA2, 128'hA3);
        tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL queued_ready_run: got %b expected 1", a_in_ready); end
        offer(128'hB0, 128'hB1, 128'hB2, 128'hB3);
        tick();
        in_valid = 1'b0;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL queued_ready_full: got %b expected 0", a_in_ready); end
        checks++; if (a_core_pt0 !== 128'hA0) begin errors++; $display("FAIL queued_active_kept: got %h expected a0", a_core_pt0); end
        repeat (5) tick();
        core_done = 1'b1; core_ct0 = 128'h77; core_ct1 = 128'h0;
        tick();
        core_done = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL queued_out: got v=%b rdy=%b expected 1/0", a_out_valid, a_in_ready); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (a_core_rst !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL queued_resume: got rst=%b busy=%b expected 0/1", a_core_rst, a_busy); end
        checks++; if (a_core_pt0 !== 128'hB0 || a_core_key1 !== 128'hB3) begin errors++; $display("FAIL queued_promoted: got %h/%h expected b0/b3", a_core_pt0, a_core_key1); end
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL queued_next_empty: got rdy=%b v=%b expected 1/0", a_in_ready, a_out_valid); end
        $display("test_queued done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        offer(128'hC0, 128'hC1, 128'hC2, 128'hC3);
        tick();
        in_valid = 1'b0; core_done = 1'b1; core_ct0 = 128'h5; core_ct1 = 128'h6;
        tick();
        core_done = 1'b0;
        offer(128'hD0, 128'hD1, 128'hD2, 128'hD3);
        out_ready = 1'b1;
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin errors++; $display("FAIL simul_out: got rdy=%b v=%b expected 1/1", a_in_ready, a_out_valid); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (a_core_rst !== 1'b0 || a_core_pt1 !== 128'hD1) begin errors++; $display("FAIL simul_run: got rst=%b pt1=%h expected 0/d1", a_core_rst, a_core_pt1); end
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL simul_next_empty: got rdy=%b v=%b expected 1/0", a_in_ready, a_out_valid); end
        $display("test_simultaneous done");
    endtask

    task automatic test_capture_delay();
        do_reset();
        offer(128'hE0, 128'hE1, 128'hE2, 128'hE3);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        for (int k = 0; k <= 6; k++) begin
            core_done = (k < 3);
            core_ct0 = 128'hABCD0000 + W'(k);
            core_ct1 = W'(k * 3);
            tick();
            if (k < 6) begin
                checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b1 || b_core_rst !== 1'b0) begin errors++; $display("FAIL cap_wait_%0d: got v=%b busy=%b rst=%b expected 0/1/0", k, b_out_valid, b_busy, b_core_rst); end
            end
        end
        core_done = 1'b0;
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL cap_out_valid: got %b expected 1", b_out_valid); end
        checks++; if (b_out_ct0 !== 128'hABCD0006 || b_out_ct1 !== 128'd18) begin errors++; $display("FAIL cap_value: got %h/%h expected abcd0006/12", b_out_ct0, b_out_ct1); end
        $display("test_capture_delay done");
    endtask

    task automatic test_watchdog();
        do_reset();
        offer(128'hF0, 128'hF1, 128'hF2, 128'hF3);
        tick();
        in_valid = 1'b0;
        repeat (99) tick();
        checks++; if (a_busy !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL wd_cycle100: got busy=%b err=%b expected 1/0", a_busy, a_err); end
        tick();
        checks++; if (a_err !== 1'b1 || a_core_rst !== 1'b1) begin errors++; $display("FAIL wd_err: got err=%b rst=%b expected 1/1", a_err, a_core_rst); end
        checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL wd_err_outputs: got rdy=%b v=%b busy=%b expected 0/0/0", a_in_ready, a_out_valid, a_busy); end
        offer(128'h1, 128'h2, 128'h3, 128'h4); core_done = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0; core_done = 1'b0;
        checks++; if (a_err !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL wd_sticky: got err=%b rdy=%b expected 1/0", a_err, a_in_ready); end
        rst = 1'b0; tick(); rst = 1'b1;
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL wd_reset_clears: got %b expected 0", a_err); end
        offer(128'hF0, 128'hF1, 128'hF2, 128'hF3);
        tick();
        in_valid = 1'b0;
        repeat (99) tick();
        core_done = 1'b1; core_ct0 = 128'h99; core_ct1 = 128'h0;
        tick();
        core_done = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_err !== 1'b0 || a_out_ct0 !== 128'h99) begin errors++; $display("FAIL wd_coincide: got v=%b err=%b ct0=%h expected 1/0/99", a_out_valid, a_err, a_out_ct0); end
        $display("test_watchdog done");
    endtask

    task automatic test_reset_in_cap();
        do_reset();
        offer(128'h10, 128'h11, 128'h12, 128'h13);
        tick();
        offer(128'h20, 128'h21, 128'h22, 128'h23);
        tick();
        in_valid = 1'b0; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++; if (b_busy !== 1'b1 || b_in_ready !== 1'b0) begin errors++; $display("FAIL rcap_in_cap: got busy=%b rdy=%b expected 1/0", b_busy, b_in_ready); end
        repeat (2) tick();
        rst = 1'b0; tick();
        checks++; if (b_in_ready !== 1'b0 || b_core_rst !== 1'b1 || b_busy !== 1'b0) begin errors++; $display("FAIL rcap_reset_vals: got rdy=%b rst=%b busy=%b expected 0/1/0", b_in_ready, b_core_rst, b_busy); end
        checks++; if (b_core_pt0 !== '0 || b_out_valid !== 1'b0 || b_out_ct0 !== '0) begin errors++; $display("FAIL rcap_reset_data: got pt0=%h v=%b ct0=%h expected 0/0/0", b_core_pt0, b_out_valid, b_out_ct0); end
        rst = 1'b1; tick();
        checks++; if (b_in_ready !== 1'b1 || b_core_rst !== 1'b1 || b_core_pt0 !== '0) begin errors++; $display("FAIL rcap_queue_lost: got rdy=%b rst=%b pt0=%h expected 1/1/0", b_in_ready, b_core_rst, b_core_pt0); end
        $display("test_reset_in_cap done");
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(128'h30, 128'h31, 128'h32, 128'h33);
        tick();
        in_valid = 1'b0; core_done = 1'b1; core_ct0 = 128'h1234; core_ct1 = 128'h5678;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            core_ct0 = W'(i) ^ 128'hFF00;
            if (i == 2) begin
                offer(128'h40, 128'h41, 128'h42, 128'h43);
                checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", a_in_ready); end
            end
            tick();
            checks++; if (a_out_valid !== 1'b1 || a_core_rst !== 1'b1 || a_out_ct0 !== 128'h1234 || a_out_ct1 !== 128'h5678) begin errors++; $display("FAIL bp_hold_%0d: got v=%b rst=%b ct=%h/%h expected 1/1/1234/5678", i, a_out_valid, a_core_rst, a_out_ct0, a_out_ct1); end
            if (i >= 2) begin
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_%0d: got %b expected 0", i, a_in_ready); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (a_core_rst !== 1'b0 || a_core_pt0 !== 128'h40 || a_core_key0 !== 128'h42) begin errors++; $display("FAIL bp_promote: got rst=%b pt0=%h key0=%h expected 0/40/42", a_core_rst, a_core_pt0, a_core_key0); end
        $display("test_backpressure done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_simultaneous();
        test_capture_delay();
        test_watchdog();
        test_reset_in_cap();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
